// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-access sequencer.
package spi_reg_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StCmd   = 3'd1;
    localparam state_t StWr    = 3'd2;
    localparam state_t StWrBus = 3'd3;
    localparam state_t StRd    = 3'd4;
    localparam state_t StRdBus = 3'd5;

    // Upper nibble of every status byte, lets the host recognise a live slave
    localparam logic [3:0] STATUS_SIG = 4'hA;

    // Command byte bit selecting write (1) or read (0)
    localparam int unsigned CMD_WR_BIT = 7;

    // Status byte returned on MISO while no read data is staged
    function automatic logic [7:0] status_byte(input logic ovr, input logic tmo);
        return {STATUS_SIG, ovr, tmo, 2'b00};
    endfunction

endpackage

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer behind a byte-level SPI slave: frames on ss, decodes a command byte,
// then runs auto-incrementing burst writes/reads on a req/ack register bus. Read data is
// prefetched one byte ahead so the slave always has its next transmit byte loaded in time.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [7:0]  RD_ERR  = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              spi_done,
    input  logic [7:0]        spi_dout,
    output logic [7:0]        spi_din,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_ack,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic              ss_meta_q, ss_sync_q;
    logic              frame_open;
    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        din_q, din_d;
    logic              ovr_q, ovr_d;
    logic              tmo_q, tmo_d;
    logic [1:0]        snap_q, snap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_end;

    assign frame_open = ~ss_sync_q;
    assign bus_end    = reg_ack || (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state logic: framing, command decode, bus handshakes, timeout and overrun flags
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        din_d   = din_q;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // Snapshot tracks live flags until the frame opens, then freezes
                snap_d = {ovr_q, tmo_q};
                din_d  = status_byte(snap_q[1], snap_q[0]);
                if (frame_open) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                din_d = status_byte(snap_q[1], snap_q[0]);
                if (!frame_open) begin
                    state_d = StIdle;
                end else if (spi_done) begin
                    ovr_d  = 1'b0;
                    tmo_d  = 1'b0;
                    addr_d = spi_dout[ADDR_W-1:0];
                    if (spi_dout[CMD_WR_BIT]) begin
                        state_d = StWr;
                    end else begin
                        // Prefetch the first read so it is ready for frame byte 3
                        state_d = StRdBus;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            StWr: begin
                if (!frame_open) begin
                    state_d = StIdle;
                end else if (spi_done) begin
                    state_d = StWrBus;
                    wdata_d = spi_dout;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            StRd: begin
                if (!frame_open) begin
                    state_d = StIdle;
                end else if (spi_done) begin
                    state_d = StRdBus;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StWrBus, StRdBus: begin
                // A byte completing mid-transaction has nowhere to go
                if (frame_open && spi_done) begin
                    ovr_d = 1'b1;
                end
                if (bus_end) begin
                    req_d  = 1'b0;
                    addr_d = addr_q + ADDR_W'(1);
                    if (!reg_ack) begin
                        tmo_d = 1'b1;
                    end
                    if (state_q == StRdBus && frame_open) begin
                        din_d = reg_ack ? reg_rdata : RD_ERR;
                    end
                    if (!frame_open) begin
                        state_d = StIdle;
                    end else begin
                        state_d = (state_q == StWrBus) ? StWr : StRd;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers and two-flop ss synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_meta_q <= 1'b1;
            ss_sync_q <= 1'b1;
            state_q   <= StIdle;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            din_q     <= status_byte(1'b0, 1'b0);
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            snap_q    <= '0;
            cnt_q     <= '0;
        end else begin
            ss_meta_q <= ss;
            ss_sync_q <= ss_meta_q;
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            din_q     <= din_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
        end
    end

    assign spi_din   = din_q;
    assign reg_req   = req_q;
    assign reg_we    = we_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: byte-level SPI host, register-file responder and a
// frame-level reference model of the expected bus transactions and MISO bytes.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss = 1'b1;
    logic       spi_done = 1'b0;
    logic [7:0] spi_dout = 8'h00;
    logic [7:0] spi_din;
    logic       reg_req;
    logic       reg_we;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;
    logic       busy;

    always #5 clk = ~clk;

    spi_reg_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .spi_done  (spi_done),
        .spi_dout  (spi_dout),
        .spi_din   (spi_din),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .busy      (busy)
    );

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem [128];      // register file behind the bus (responder-owned)
    logic [7:0]  ref_mem [128];  // model's view of the register file
    logic [15:0] act_log [$];    // {we, addr, wdata} seen on the bus
    logic [15:0] exp_log [$];
    int          log_ci = 0;
    int          ack_delay = 2;
    bit          ack_enable = 1'b1;
    int          last_req_len = 0;
    logic [7:0]  tx_q [$];
    logic [7:0]  miso_q [$];
    bit          mdl_ovr = 1'b0;
    bit          mdl_tmo = 1'b0;

    // Register-file responder: acks after ack_delay cycles, logs each request, measures req width
    initial begin
        bit active;
        int cnt;
        int run;
        active = 1'b0;
        cnt = 0;
        run = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            if (reg_req) run++;
            else if (run != 0) begin
                last_req_len = run;
                run = 0;
            end
            if (active) begin
                if (!reg_req) active = 1'b0;
                else if (cnt >= ack_delay && ack_enable) begin
                    reg_ack   = 1'b1;
                    reg_rdata = mem[reg_addr];
                    if (reg_we) mem[reg_addr] = reg_wdata;
                    active = 1'b0;
                end else cnt++;
            end else if (reg_req) begin
                active = 1'b1;
                cnt = 1;
                act_log.push_back({reg_we, reg_addr, reg_we ? reg_wdata : 8'h00});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_txn_count"}, act_log.size(), exp_log.size());
        for (int k = log_ci; k < exp_log.size() && k < act_log.size(); k++)
            check($sformatf("%s_txn%0d", tag, k), act_log[k], exp_log[k]);
        log_ci = exp_log.size();
    endtask

    // Drive one frame of tx_q; miso_q[k] is the byte the slave shifts out as frame byte k+1
    task automatic run_frame(input int gap);
        int guard;
        miso_q.delete();
        @(negedge clk);
        miso_q.push_back(spi_din);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        foreach (tx_q[k]) begin
            repeat (gap - 1) @(negedge clk);
            spi_dout = tx_q[k];
            spi_done = 1'b1;
            miso_q.push_back(spi_din);
            @(negedge clk);
            spi_done = 1'b0;
        end
        repeat (gap) @(negedge clk);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("frame_busy_low", busy, 0);
        repeat (4) @(negedge clk);
    endtask

    // mode 0: normal, 1: every read times out, 2: second write byte overruns
    task automatic do_frame(input string tag, input int gap, input int mode);
        logic [7:0] st;
        logic [6:0] a;
        logic [6:0] ai;
        bit         wr;
        int         n;
        int         nb;
        logic [7:0] exp_miso [$];
        st = {4'hA, mdl_ovr, mdl_tmo, 2'b00};
        mdl_ovr = 1'b0;
        mdl_tmo = 1'b0;
        wr = tx_q[0][7];
        a  = tx_q[0][6:0];
        n  = tx_q.size() - 1;
        exp_miso.push_back(st);
        exp_miso.push_back(st);
        for (int i = 0; i <= n; i++) begin
            ai = a + 7'(i);
            if (wr) begin
                if (i < n && (mode != 2 || i == 0)) begin
                    exp_log.push_back({1'b1, ai, tx_q[i+1]});
                    ref_mem[ai] = tx_q[i+1];
                end
            end else begin
                exp_log.push_back({1'b0, ai, 8'h00});
                if (i < n - 1) exp_miso.push_back(mode == 1 ? 8'hEE : ref_mem[ai]);
            end
        end
        run_frame(gap);
        if (mode == 1) mdl_tmo = 1'b1;
        if (mode == 2) mdl_ovr = 1'b1;
        nb = wr ? 2 : n + 1;
        for (int k = 0; k < nb; k++)
            check($sformatf("%s_miso%0d", tag, k), miso_q[k], exp_miso[k]);
        compare_log(tag);
    endtask

    initial begin
        int guard;
        int mism;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
        @(negedge clk);
        check("rst_req", reg_req, 0);
        check("rst_we", reg_we, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_din", spi_din, 8'hA0);

        // Write burst 05,06
        tx_q = {8'h85, 8'h11, 8'h22};
        do_frame("t1", 12, 0);
        check("t1_mem05", mem[5], 8'h11);
        check("t1_mem06", mem[6], 8'h22);

        // Load 10/11 then read back with prefetch
        tx_q = {8'h90, 8'hAB, 8'hCD};
        do_frame("t2w", 12, 0);
        tx_q = {8'h10, 8'($urandom), 8'($urandom), 8'($urandom)};
        do_frame("t2r", 12, 0);

        // Address wrap 7E,7F,00
        tx_q = {8'hFE, 8'h01, 8'h02, 8'h03};
        do_frame("t3", 12, 0);

        // Read timeouts
        ack_enable = 1'b0;
        tx_q = {8'h20, 8'h00, 8'h00};
        do_frame("t4", 24, 1);
        check("t4_req_len", last_req_len, 16);
        ack_enable = 1'b1;

        // Overrun on a slow write ack; status must show A4 then A8 then A0
        ack_delay = 10;
        tx_q = {8'hC8, 8'h3C, 8'hC3};
        do_frame("t5", 6, 2);
        ack_delay = 2;
        tx_q = {8'h01, 8'h00};
        do_frame("t5b", 12, 0);
        tx_q = {8'h81, 8'h77};
        do_frame("t5c", 12, 0);

        // Close during read: txn completes, data discarded, din back to status
        tx_q = {8'hB0, 8'h5A};
        do_frame("t6w", 12, 0);
        ack_delay = 8;
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_dout = 8'h30;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        exp_log.push_back({1'b0, 7'h30, 8'h00});
        ss = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_req_held", reg_req, 1);
        check("t6_busy_held", busy, 1);
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("t6_busy_low", busy, 0);
        repeat (3) @(negedge clk);
        check("t6_din_status", spi_din, 8'hA0);
        compare_log("t6");
        ack_delay = 2;

        // Reset while a request is outstanding
        ack_enable = 1'b0;
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_dout = 8'h40;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        exp_log.push_back({1'b0, 7'h40, 8'h00});
        repeat (3) @(negedge clk);
        check("rst_mid_req_before", reg_req, 1);
        rst = 1'b1;
        ss = 1'b1;
        @(negedge clk);
        check("rst_mid_req", reg_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_addr", reg_addr, 0);
        check("rst_mid_din", spi_din, 8'hA0);
        rst = 1'b0;
        ack_enable = 1'b1;
        repeat (4) @(negedge clk);
        compare_log("rst_mid");

        // Random bursts
        for (int f = 0; f < 12; f++) begin
            tx_q.delete();
            tx_q.push_back(8'($urandom));
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
            ack_delay = $urandom_range(1, 4);
            do_frame($sformatf("rnd%0d", f), 12, 0);
        end

        mism = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_final", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
